// File: rtl/mem_master.sv
// ---------------------------------------------------------------------------
// mem_master
//
// Bus initiator between the CPU load/store stage and a `mem` responder.
// Accepts one byte or 16-bit word load/store at a time and issues the
// matching memory transactions. Load data is lane-extracted and sign/zero
// extended. A per-transaction timeout aborts a transaction whose responder
// never answers.
//
// Optional feature macro: MEM_MASTER_MISALIGN_EN
//   defined   : misaligned (odd address) word accesses are split into two
//               byte-lane transactions separated by a one-cycle gap.
//   undefined : misaligned word accesses are rejected with done+err one
//               cycle after acceptance and no memory transaction.
//
// Parameters
//   TIMEOUT    cycles mem_vaild may stay high without mem_ready (1..65535)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req                   request, accepted on an edge while idle
//   req_we                1 = store, 0 = load
//   req_byte              1 = byte access, 0 = 16-bit word access
//   req_sext              byte loads: 1 = sign-extend, 0 = zero-extend
//   req_addr[15:0]        byte address
//   req_wdata[15:0]       store data (byte stores use [7:0])
//   busy                  high from the cycle after acceptance until done
//   done                  one-cycle completion pulse
//   err                   with done: timeout or rejected access
//   rdata[15:0]           load result, updated only on a successful load
//   mem_vaild, mem_wstrb[1:0], mem_addr[15:0], mem_din[15:0]
//                         request to memory (wstrb 00 rd, 01 byte wr, 10 word wr)
//   mem_dout[15:0], mem_ready
//                         response from memory
// ---------------------------------------------------------------------------
module mem_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_sext,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        mem_vaild,
    output logic [1:0]  mem_wstrb,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_ready
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
`ifdef MEM_MASTER_MISALIGN_EN
        GAP,
        REQ2,
`endif
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;

    // Request attributes captured at acceptance
    logic        byte_reg;
    logic        sext_reg;
    logic        lane_reg;
`ifdef MEM_MASTER_MISALIGN_EN
    logic        split_reg;
    logic        we_reg;
    logic [15:0] addr_reg;
    logic [7:0]  wdata_hi_reg;
    logic [7:0]  d1_reg, d1_next;
`endif

    // Next values of the registered outputs
    logic        busy_next, done_next, err_next, vaild_next;
    logic [15:0] rdata_next, addr_next, din_next;
    logic [1:0]  wstrb_next;

    logic        accept;
    logic        mis_req;
    logic        timeout_hit;
    logic [7:0]  byte_lane;

    assign accept      = (state_reg == IDLE) && req;
    assign mis_req     = !req_byte && req_addr[0];
    // Abort on the edge that would bring the stall count up to TIMEOUT, so
    // mem_vaild is high for exactly TIMEOUT cycles when ready never comes.
    assign timeout_hit = (cnt_reg + 16'd1) >= TIMEOUT_LIMIT;
    assign byte_lane   = lane_reg ? mem_dout[15:8] : mem_dout[7:0];

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_reg     <= 1'b0;
            sext_reg     <= 1'b0;
            lane_reg     <= 1'b0;
`ifdef MEM_MASTER_MISALIGN_EN
            split_reg    <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= 16'h0000;
            wdata_hi_reg <= 8'h00;
`endif
        end else if (accept) begin
            byte_reg     <= req_byte;
            sext_reg     <= req_sext;
            lane_reg     <= req_addr[0];
`ifdef MEM_MASTER_MISALIGN_EN
            split_reg    <= mis_req;
            we_reg       <= req_we;
            addr_reg     <= req_addr;
            wdata_hi_reg <= req_wdata[15:8];
`endif
        end
    end

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 16'h0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 16'h0000;
            mem_vaild <= 1'b0;
            mem_wstrb <= 2'b00;
            mem_addr  <= 16'h0000;
            mem_din   <= 16'h0000;
`ifdef MEM_MASTER_MISALIGN_EN
            d1_reg    <= 8'h00;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy      <= busy_next;
            done      <= done_next;
            err       <= err_next;
            rdata     <= rdata_next;
            mem_vaild <= vaild_next;
            mem_wstrb <= wstrb_next;
            mem_addr  <= addr_next;
            mem_din   <= din_next;
`ifdef MEM_MASTER_MISALIGN_EN
            d1_reg    <= d1_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy_next  = busy;
        done_next  = 1'b0;
        err_next   = 1'b0;
        rdata_next = rdata;
        vaild_next = mem_vaild;
        wstrb_next = mem_wstrb;
        addr_next  = mem_addr;
        din_next   = mem_din;
`ifdef MEM_MASTER_MISALIGN_EN
        d1_next    = d1_reg;
`endif

        case (state_reg)
            IDLE: begin
                busy_next  = 1'b0;
                vaild_next = 1'b0;
                if (req) begin
                    busy_next = 1'b1;
`ifndef MEM_MASTER_MISALIGN_EN
                    if (mis_req) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end else
`endif
                    begin
                        state_next = REQ1;
                        vaild_next = 1'b1;
                        cnt_next   = 16'h0000;
                        // Reads always address the aligned word; writes
                        // carry the exact byte address.
                        addr_next  = req_we ? req_addr : {req_addr[15:1], 1'b0};
                        if (!req_we) begin
                            wstrb_next = 2'b00;
                            din_next   = 16'h0000;
                        end else if (req_byte || mis_req) begin
                            wstrb_next = 2'b01;
                            din_next   = {8'h00, req_wdata[7:0]};
                        end else begin
                            wstrb_next = 2'b10;
                            din_next   = req_wdata;
                        end
                    end
                end
            end

            REQ1: begin
                if (mem_ready) begin
                    vaild_next = 1'b0;
`ifdef MEM_MASTER_MISALIGN_EN
                    if (split_reg) begin
                        state_next = GAP;
                        d1_next    = mem_dout[15:8];
                    end else
`endif
                    begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        if (mem_wstrb == 2'b00) begin
                            rdata_next = byte_reg
                                ? {{8{sext_reg & byte_lane[7]}}, byte_lane}
                                : mem_dout;
                        end
                    end
                end else if (timeout_hit) begin
                    vaild_next = 1'b0;
                    state_next = DONE;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

`ifdef MEM_MASTER_MISALIGN_EN
            GAP: begin
                state_next = REQ2;
                vaild_next = 1'b1;
                cnt_next   = 16'h0000;
                // Odd A plus one is the next aligned word / upper byte;
                // wraps from 0xFFFF to 0x0000.
                addr_next  = addr_reg + 16'd1;
                if (we_reg) begin
                    wstrb_next = 2'b01;
                    din_next   = {8'h00, wdata_hi_reg};
                end else begin
                    wstrb_next = 2'b00;
                    din_next   = 16'h0000;
                end
            end

            REQ2: begin
                if (mem_ready) begin
                    vaild_next = 1'b0;
                    state_next = DONE;
                    done_next  = 1'b1;
                    if (!we_reg) begin
                        rdata_next = {mem_dout[7:0], d1_reg};
                    end
                end else if (timeout_hit) begin
                    vaild_next = 1'b0;
                    state_next = DONE;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
`endif

            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                vaild_next = 1'b0;
            end
        endcase
    end

endmodule
